ps2_keyboard: RTL and testbench

PS/2 keyboard front end for the DCPU-16 generic keyboard device. Receives PS/2 device-to-host frames on the board PS2_CLK/PS2_DAT pins, decodes Set-2 make/break scan codes into DCPU generic-keyboard key codes, and buffers them in a small FIFO. The CPU-side hardware-interrupt handler consumes keys through a pop/clear handshake. Sits between the top-level PS/2 pins and the CPU's hardware bus, in the CLOCK_50 domain.

---
 rtl/dcpu_kbd_pkg.sv | 83 ++++++++
 rtl/ps2_rx.sv | 110 +++++++++++
 rtl/ps2_keyboard.sv | 114 +++++++++++
 tb/tb_ps2_keyboard.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcpu_kbd_pkg.sv
// Shared types and constants for the DCPU-16 generic keyboard front end:
// receiver state encoding, DCPU key codes and the Set-2 scan code translation.
package dcpu_kbd_pkg;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  localparam logic [7:0] KEY_BACKSPACE = 8'h10;
  localparam logic [7:0] KEY_RETURN    = 8'h11;
  localparam logic [7:0] KEY_INSERT    = 8'h12;
  localparam logic [7:0] KEY_DELETE    = 8'h13;
  localparam logic [7:0] KEY_UP        = 8'h80;
  localparam logic [7:0] KEY_DOWN      = 8'h81;
  localparam logic [7:0] KEY_LEFT      = 8'h82;
  localparam logic [7:0] KEY_RIGHT     = 8'h83;
  localparam logic [7:0] KEY_SHIFT     = 8'h90;
  localparam logic [7:0] KEY_CONTROL   = 8'h91;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;

  // Returns {hit, key}; hit=0 means the code has no DCPU equivalent.
  function automatic logic [8:0] scancode_to_key(input logic [7:0] code,
                                                 input logic ext,
                                                 input logic shift);
    logic [7:0] k;
    logic       hit;
    hit = 1'b1;
    k   = 8'h00;
    if (code == SC_CTRL) k = KEY_CONTROL;
    else if (code == SC_LSHIFT || code == SC_RSHIFT) k = KEY_SHIFT;
    else if (code == 8'h66) k = KEY_BACKSPACE;
    else if (code == 8'h5A) k = KEY_RETURN;
    else if (ext) begin
      case (code)
        8'h70:   k = KEY_INSERT;
        8'h71:   k = KEY_DELETE;
        8'h75:   k = KEY_UP;
        8'h72:   k = KEY_DOWN;
        8'h6B:   k = KEY_LEFT;
        8'h74:   k = KEY_RIGHT;
        default: hit = 1'b0;
      endcase
    end else begin
      case (code)
        8'h1C: k = shift ? "A" : "a";   8'h32: k = shift ? "B" : "b";
        8'h21: k = shift ? "C" : "c";   8'h23: k = shift ? "D" : "d";
        8'h24: k = shift ? "E" : "e";   8'h2B: k = shift ? "F" : "f";
        8'h34: k = shift ? "G" : "g";   8'h33: k = shift ? "H" : "h";
        8'h43: k = shift ? "I" : "i";   8'h3B: k = shift ? "J" : "j";
        8'h42: k = shift ? "K" : "k";   8'h4B: k = shift ? "L" : "l";
        8'h3A: k = shift ? "M" : "m";   8'h31: k = shift ? "N" : "n";
        8'h44: k = shift ? "O" : "o";   8'h4D: k = shift ? "P" : "p";
        8'h15: k = shift ? "Q" : "q";   8'h2D: k = shift ? "R" : "r";
        8'h1B: k = shift ? "S" : "s";   8'h2C: k = shift ? "T" : "t";
        8'h3C: k = shift ? "U" : "u";   8'h2A: k = shift ? "V" : "v";
        8'h1D: k = shift ? "W" : "w";   8'h22: k = shift ? "X" : "x";
        8'h35: k = shift ? "Y" : "y";   8'h1A: k = shift ? "Z" : "z";
        8'h45: k = shift ? ")" : "0";   8'h16: k = shift ? "!" : "1";
        8'h1E: k = shift ? "@" : "2";   8'h26: k = shift ? "#" : "3";
        8'h25: k = shift ? "$" : "4";   8'h2E: k = shift ? "%" : "5";
        8'h36: k = shift ? "^" : "6";   8'h3D: k = shift ? "&" : "7";
        8'h3E: k = shift ? "*" : "8";   8'h46: k = shift ? "(" : "9";
        8'h0E: k = shift ? "~" : 8'h60; 8'h4E: k = shift ? "_" : "-";
        8'h55: k = shift ? "+" : "=";   8'h54: k = shift ? "{" : "[";
        8'h5B: k = shift ? "}" : "]";   8'h5D: k = shift ? "|" : "\\";
        8'h4C: k = shift ? ":" : ";";   8'h52: k = shift ? "\"" : "'";
        8'h41: k = shift ? "<" : ",";   8'h49: k = shift ? ">" : ".";
        8'h4A: k = shift ? "?" : "/";   8'h29: k = " ";
        default: hit = 1'b0;
      endcase
    end
    return {hit, k};
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: pin synchronisers, clock glitch filter,
// frame FSM with parity/stop checking and an idle timeout for partial frames.
module ps2_rx
  import dcpu_kbd_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err,
  output rx_state_t  state
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;

  // The filtered clock only moves after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      fall     <= 1'b0;
      if (clk_sync[1] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_sync[1];
        filt_cnt <= '0;
        fall     <= ~clk_sync[1];
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RX_IDLE;
      timer      <= '0;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      par_bit    <= 1'b0;
      rx_byte    <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == RX_IDLE || fall) begin
        timer <= '0;
      end else if (timer == TW'(TIMEOUT - 1)) begin
        timer     <= '0;
        state     <= RX_IDLE;
        frame_err <= 1'b1;
      end else begin
        timer <= timer + TW'(1);
      end
      if (fall) begin
        case (state)
          RX_IDLE: begin
            if (!dat_sync[1]) begin
              state   <= RX_DATA;
              bit_cnt <= 3'd0;
            end
          end
          RX_DATA: begin
            shreg   <= {dat_sync[1], shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= RX_PARITY;
          end
          RX_PARITY: begin
            par_bit <= dat_sync[1];
            state   <= RX_STOP;
          end
          RX_STOP: begin
            state <= RX_IDLE;
            if (dat_sync[1] && (^{shreg, par_bit})) begin
              rx_byte    <= shreg;
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// DCPU-16 generic keyboard front end: PS/2 receiver, Set-2 make/break decoder
// and a small key FIFO drained by the CPU interrupt handler.
module ps2_keyboard
  import dcpu_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic                          CLOCK_50,
  input  logic                          RESET,
  input  logic                          PS2_CLK,
  input  logic                          PS2_DAT,
  input  logic                          key_pop,
  input  logic                          key_clear,
  output logic                          key_valid,
  output logic [15:0]                   key_code,
  output logic [$clog2(FIFO_DEPTH):0]   key_count,
  output logic                          irq,
  output logic                          frame_err,
  output rx_state_t                     rx_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    rx_byte;
  logic          byte_valid;
  logic          ext;
  logic          brk;
  logic          shift;
  logic [8:0]    lookup;
  logic          is_prefix;
  logic          is_shift_code;
  logic          push;
  logic          push_ok;
  logic          pop_ok;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) u_rx (
    .clk       (CLOCK_50),
    .rst       (RESET),
    .ps2_clk   (PS2_CLK),
    .ps2_dat   (PS2_DAT),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err),
    .state     (rx_state)
  );

  always_comb begin
    lookup        = scancode_to_key(rx_byte, ext, shift);
    is_prefix     = (rx_byte == SC_EXT) || (rx_byte == SC_BREAK);
    is_shift_code = (rx_byte == SC_LSHIFT) || (rx_byte == SC_RSHIFT);
    push          = byte_valid && !is_prefix && !brk && lookup[8];
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      ext   <= 1'b0;
      brk   <= 1'b0;
      shift <= 1'b0;
    end else if (byte_valid) begin
      if (rx_byte == SC_EXT) begin
        ext <= 1'b1;
      end else if (rx_byte == SC_BREAK) begin
        brk <= 1'b1;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
        if (is_shift_code) shift <= ~brk;
      end
    end
  end

  // Handshake: key_pop consumes the head only while key_valid is high and the
  // next head is visible the following cycle; key_clear wins over push and pop.
  // A push into a full FIFO succeeds only if a pop frees the slot that cycle.
  assign pop_ok  = key_pop && (count != '0);
  assign push_ok = push && ((count != CW'(FIFO_DEPTH)) || pop_ok);
  assign irq     = push_ok && !key_clear;

  always_ff @(posedge CLOCK_50) begin
    if (irq) mem[wr_ptr] <= lookup[7:0];
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (key_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign key_valid = (count != '0);
  assign key_count = count;
  assign key_code  = key_valid ? {8'h00, mem[rd_ptr]} : 16'h0000;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: PS/2 frames are bit-banged on the pins and
// the resulting keys, interrupts and frame errors are checked against hand values.
module tb_ps2_keyboard;
  import dcpu_kbd_pkg::*;

  localparam int HALF = 20;

  logic        CLOCK_50 = 1'b0;
  logic        RESET = 1'b1;
  logic        PS2_CLK = 1'b1;
  logic        PS2_DAT = 1'b1;
  logic        key_pop = 1'b0;
  logic        key_clear = 1'b0;
  logic        key_valid;
  logic [15:0] key_code;
  logic [3:0]  key_count;
  logic        irq;
  logic        frame_err;
  rx_state_t   rx_state;

  int n_vec = 0;
  int n_err = 0;
  int irq_cnt = 0;
  int err_cnt = 0;

  ps2_keyboard dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .PS2_CLK  (PS2_CLK),
    .PS2_DAT  (PS2_DAT),
    .key_pop  (key_pop),
    .key_clear(key_clear),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_count(key_count),
    .irq      (irq),
    .frame_err(frame_err),
    .rx_state (rx_state)
  );

  // clock / reset block
  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    if (irq) irq_cnt <= irq_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
  end

  initial begin
    #2500000;
    $display("FAIL watchdog: simulation time exhausted, want completion");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic ps2_bit(input logic b);
    PS2_DAT = b;
    wait_cycles(HALF);
    PS2_CLK = 1'b0;
    wait_cycles(HALF);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par = 1'b0);
    logic p;
    p = (~^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(1'b1);
    PS2_DAT = 1'b1;
    wait_cycles(3 * HALF);
  endtask

  task automatic pop_key(output logic [15:0] code, output logic valid);
    @(negedge CLOCK_50);
    code = key_code;
    valid = key_valid;
    key_pop = 1'b1;
    @(negedge CLOCK_50);
    key_pop = 1'b0;
  endtask

  // Waits for the decoder's byte strobe and pulses pop or clear in that same cycle.
  task automatic strobe_pulse(input logic do_clear, output logic found, output logic irq_seen);
    found = 1'b0;
    irq_seen = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge CLOCK_50);
      if (dut.byte_valid) begin
        found = 1'b1;
        if (do_clear) key_clear = 1'b1;
        else key_pop = 1'b1;
        #1;
        irq_seen = irq;
        @(negedge CLOCK_50);
        key_pop = 1'b0;
        key_clear = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    wait_cycles(5);
    RESET = 1'b0;
    wait_cycles(3);
    n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    n_vec++; if (key_code !== 16'h0000) begin n_err++; $display("FAIL reset_code: got %h want 0000", key_code); end
    n_vec++; if (key_count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", key_count); end
    n_vec++; if (rx_state !== RX_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want 0", rx_state); end
    n_vec++; if ({irq, frame_err} !== 2'b00) begin n_err++; $display("FAIL reset_pulses: got %b want 00", {irq, frame_err}); end
  endtask

  task automatic test_single_key();
    int i0;
    logic [15:0] c;
    logic v;
    i0 = irq_cnt;
    send_frame(8'h1C);
    n_vec++; if (irq_cnt - i0 !== 1) begin n_err++; $display("FAIL single_irq: got %0d pulses want 1", irq_cnt - i0); end
    n_vec++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", key_valid); end
    n_vec++; if (key_code !== 16'h0061) begin n_err++; $display("FAIL single_code: got %h want 0061", key_code); end
    n_vec++; if (key_count !== 4'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", key_count); end
    pop_key(c, v);
    n_vec++; if (key_count !== 4'd0) begin n_err++; $display("FAIL single_pop_count: got %0d want 0", key_count); end
  endtask

  task automatic test_shift_seq();
    logic [7:0]  seq [7] = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C};
    logic [15:0] exp_q[$] = '{16'h0090, 16'h0041, 16'h0061};
    logic [15:0] c;
    logic v;
    foreach (seq[i]) send_frame(seq[i]);
    n_vec++; if (key_count !== 4'd3) begin n_err++; $display("FAIL shift_count: got %0d want 3", key_count); end
    while (exp_q.size() > 0) begin
      pop_key(c, v);
      n_vec++; if (v !== 1'b1 || c !== exp_q[0]) begin n_err++; $display("FAIL shift_key: got %h valid %b want %h", c, v, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_extended();
    logic [7:0] seq [5] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    logic [15:0] c;
    logic v;
    foreach (seq[i]) send_frame(seq[i]);
    n_vec++; if (key_count !== 4'd1) begin n_err++; $display("FAIL ext_count: got %0d want 1", key_count); end
    pop_key(c, v);
    n_vec++; if (c !== 16'h0080) begin n_err++; $display("FAIL ext_key: got %h want 0080", c); end
  endtask

  task automatic test_bad_parity();
    int e0;
    logic [15:0] c;
    logic v;
    e0 = err_cnt;
    send_frame(8'h5A, 1'b1);
    send_frame(8'h5A);
    n_vec++; if (err_cnt - e0 !== 1) begin n_err++; $display("FAIL parity_err: got %0d pulses want 1", err_cnt - e0); end
    n_vec++; if (key_count !== 4'd1) begin n_err++; $display("FAIL parity_count: got %0d want 1", key_count); end
    pop_key(c, v);
    n_vec++; if (c !== 16'h0011) begin n_err++; $display("FAIL parity_key: got %h want 0011", c); end
  endtask

  task automatic test_timeout();
    int e0;
    logic [15:0] c;
    logic v;
    e0 = err_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    PS2_DAT = 1'b1;
    n_vec++; if (rx_state !== RX_DATA) begin n_err++; $display("FAIL timeout_mid_state: got %0d want 1", rx_state); end
    wait_cycles(49900);
    n_vec++; if (err_cnt - e0 !== 0) begin n_err++; $display("FAIL timeout_early: got %0d pulses want 0", err_cnt - e0); end
    wait_cycles(200);
    n_vec++; if (err_cnt - e0 !== 1) begin n_err++; $display("FAIL timeout_err: got %0d pulses want 1", err_cnt - e0); end
    n_vec++; if (rx_state !== RX_IDLE) begin n_err++; $display("FAIL timeout_state: got %0d want 0", rx_state); end
    send_frame(8'h66);
    pop_key(c, v);
    n_vec++; if (c !== 16'h0010) begin n_err++; $display("FAIL timeout_next: got %h want 0010", c); end
  endtask

  task automatic test_reset_mid_frame();
    int e0;
    logic [15:0] c;
    logic v;
    e0 = err_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    PS2_DAT = 1'b1;
    RESET = 1'b1;
    wait_cycles(3);
    RESET = 1'b0;
    wait_cycles(3);
    n_vec++; if (rx_state !== RX_IDLE) begin n_err++; $display("FAIL rstmid_state: got %0d want 0", rx_state); end
    n_vec++; if (err_cnt - e0 !== 0) begin n_err++; $display("FAIL rstmid_err: got %0d pulses want 0", err_cnt - e0); end
    send_frame(8'h1C);
    pop_key(c, v);
    n_vec++; if (c !== 16'h0061) begin n_err++; $display("FAIL rstmid_next: got %h want 0061", c); end
  endtask

  task automatic test_fifo_full();
    logic [7:0]  codes [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
    logic [15:0] exp_q[$] = '{16'h0062, 16'h0063, 16'h0064, 16'h0065,
                              16'h0066, 16'h0067, 16'h0068, 16'h006A};
    logic [15:0] c;
    logic v, found, irq_seen;
    int i0;
    i0 = irq_cnt;
    foreach (codes[i]) send_frame(codes[i]);
    n_vec++; if (irq_cnt - i0 !== 8) begin n_err++; $display("FAIL full_irq: got %0d pulses want 8", irq_cnt - i0); end
    n_vec++; if (key_count !== 4'd8) begin n_err++; $display("FAIL full_count: got %0d want 8", key_count); end
    fork
      send_frame(8'h3B);
      strobe_pulse(1'b0, found, irq_seen);
    join
    n_vec++; if (found !== 1'b1 || irq_seen !== 1'b1) begin n_err++; $display("FAIL full_poppush_irq: got strobe %b irq %b want 1 1", found, irq_seen); end
    n_vec++; if (key_count !== 4'd8) begin n_err++; $display("FAIL full_poppush_count: got %0d want 8", key_count); end
    while (exp_q.size() > 0) begin
      pop_key(c, v);
      n_vec++; if (v !== 1'b1 || c !== exp_q[0]) begin n_err++; $display("FAIL full_drain: got %h valid %b want %h", c, v, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL full_empty: got %b want 0", key_valid); end
  endtask

  task automatic test_clear_push();
    logic found, irq_seen;
    int i0;
    send_frame(8'h1C);
    n_vec++; if (key_count !== 4'd1) begin n_err++; $display("FAIL clear_pre_count: got %0d want 1", key_count); end
    i0 = irq_cnt;
    fork
      send_frame(8'h32);
      strobe_pulse(1'b1, found, irq_seen);
    join
    n_vec++; if (found !== 1'b1 || irq_seen !== 1'b0) begin n_err++; $display("FAIL clear_irq: got strobe %b irq %b want 1 0", found, irq_seen); end
    n_vec++; if (irq_cnt - i0 !== 0) begin n_err++; $display("FAIL clear_irq_cnt: got %0d want 0", irq_cnt - i0); end
    n_vec++; if (key_count !== 4'd0) begin n_err++; $display("FAIL clear_count: got %0d want 0", key_count); end
    n_vec++; if (key_code !== 16'h0000) begin n_err++; $display("FAIL clear_code: got %h want 0000", key_code); end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_shift_seq();
    test_extended();
    test_bad_parity();
    test_timeout();
    test_reset_mid_frame();
    test_fifo_full();
    test_clear_push();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
